// File: rtl/audio_filter_scheduler_pkg.sv
// rtl/audio_filter_scheduler_pkg.sv - shared constants and types for the audio filter scheduler
// Purpose: stage count, stage-to-tick-rate map and FSM state encoding used by the
//          scheduler top and its round-robin arbiter.
// Ports:   none (package).
package audio_filt_pkg;

   localparam int NSTAGE = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } fsm_state_e;

   typedef enum logic {
      RATE_MID  = 1'b0,
      RATE_SLOW = 1'b1
   } rate_e;

   // Stages 0,1 run at the mid rate, stages 2,3 at the slow rate.
   function automatic rate_e stage_rate(input int st);
      return (st < 2) ? RATE_MID : RATE_SLOW;
   endfunction

endpackage

// File: rtl/audio_filter_scheduler_if.sv
// rtl/audio_filter_scheduler_if.sv - job handshake between scheduler and shared filter engine
// Purpose: groups the start/done handshake and job operands/results.
// Ports (master = scheduler side):
//   eng_start  out  1-cycle job start strobe
//   eng_ch     out  job channel, held from ISSUE through WAIT
//   eng_stage  out  job stage, held
//   eng_x      out  job input sample, held
//   eng_s      out  job stored state, held
//   eng_done   in   result valid, 1 cycle
//   eng_y      in   engine output sample, valid with eng_done
//   eng_s_nxt  in   engine next state, valid with eng_done
interface audio_filter_scheduler_if #(
   parameter int W = 12
) ();
   logic         eng_start;
   logic [1:0]   eng_ch;
   logic [1:0]   eng_stage;
   logic [W-1:0] eng_x;
   logic [W-1:0] eng_s;
   logic         eng_done;
   logic [W-1:0] eng_y;
   logic [W-1:0] eng_s_nxt;

   modport master (
      output eng_start, eng_ch, eng_stage, eng_x, eng_s,
      input  eng_done, eng_y, eng_s_nxt
   );

   modport slave (
      input  eng_start, eng_ch, eng_stage, eng_x, eng_s,
      output eng_done, eng_y, eng_s_nxt
   );
endinterface

// File: rtl/audio_filter_scheduler_rr_arbiter.sv
// rtl/audio_filter_scheduler_rr_arbiter.sv - combinational round-robin arbiter
// Purpose: grants the first requester at or after ptr_i, wrapping around.
// Ports:
//   req_i  in   N-wide request vector
//   ptr_i  in   round-robin start position
//   gnt_o  out  one-hot grant (all zero when no request)
module audio_rr_arbiter #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o
);

   logic [N-1:0] below_ptr;
   logic [N-1:0] hi_req;

   // Requests at or above the pointer win first; otherwise wrap to the lowest request.
   // x & (~x + 1) isolates the lowest set bit.
   always_comb begin
      below_ptr = (N'(1) << ptr_i) - N'(1);
      hi_req    = req_i & ~below_ptr;
      if (|hi_req) begin
         gnt_o = hi_req & (~hi_req + N'(1));
      end else begin
         gnt_o = req_i & (~req_i + N'(1));
      end
   end

endmodule

// File: rtl/audio_filter_scheduler.sv
// rtl/audio_filter_scheduler.sv - time-multiplexes one low-pass engine over NCH channels x 4 stages
// Purpose: generates mid/slow rate ticks, keeps per-(channel,stage) pending bits, picks
//          jobs round-robin across channels (highest pending stage first) and runs a
//          start/done handshake with the shared engine. Holds y and state storage.
// Ports:
//   clk_27m    in   system clock
//   reset      in   asynchronous active-high reset
//   ch_in      in   per-channel input samples, ch0 in LSBs
//   ch_out     out  per-channel stage-3 outputs
//   out_valid  out  1-cycle pulse per channel on stage-3 writeback
//   eng        --   engine handshake (master side)
//   ovr_clr    in   clears overrun flags
//   overrun    out  sticky per-channel overrun
//   err_tmo    out  sticky engine timeout, cleared only by reset
module audio_filter_scheduler
   import audio_filt_pkg::*;
#(
   parameter int NCH      = 3,
   parameter int W        = 12,
   parameter int DIV_MID  = 27,
   parameter int DIV_SLOW = 270,
   parameter int TIMEOUT  = 16
) (
   input  logic                     clk_27m,
   input  logic                     reset,
   input  logic [NCH*W-1:0]         ch_in,
   output logic [NCH*W-1:0]         ch_out,
   output logic [NCH-1:0]           out_valid,
   audio_filter_scheduler_if.master eng,
   input  logic                     ovr_clr,
   output logic [NCH-1:0]           overrun,
   output logic                     err_tmo
);

   localparam int MW = $clog2(DIV_MID);
   localparam int SW = $clog2(DIV_SLOW);
   localparam int TW = $clog2(TIMEOUT);
   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [MW-1:0] MID_LAST  = MW'(DIV_MID - 1);
   localparam logic [SW-1:0] SLOW_LAST = SW'(DIV_SLOW - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

   fsm_state_e state_q, state_d;

   logic [MW-1:0] mid_cnt_q, mid_cnt_d;
   logic [SW-1:0] slow_cnt_q, slow_cnt_d;
   logic          tick_mid, tick_slow;

   logic [NCH-1:0][NSTAGE-1:0] pend_q, pend_d;
   logic [NCH-1:0] ovr_q, ovr_d;
   logic [NCH-1:0] oval_q, oval_d;
   logic           tmo_q, tmo_d;
   logic [PW-1:0]  rr_q, rr_d;
   logic [TW-1:0]  timer_q, timer_d;

   logic [1:0]     job_ch_q, job_ch_d;
   logic [1:0]     job_stage_q, job_stage_d;
   logic [W-1:0]   job_x_q, job_x_d;
   logic [W-1:0]   job_s_q, job_s_d;

   logic [W-1:0]   ystore_q [NCH][NSTAGE];
   logic [W-1:0]   ystore_d [NCH][NSTAGE];
   logic [W-1:0]   sstore_q [NCH][NSTAGE];
   logic [W-1:0]   sstore_d [NCH][NSTAGE];

   logic [NCH-1:0] req, gnt;
   logic [1:0]     gnt_ch, sel_stage;
   logic [W-1:0]   sel_x, sel_s;
   logic           any_req;

   logic           start_o, grant_en, wb_en, tmo_hit;

   assign tick_mid  = (mid_cnt_q == MID_LAST);
   assign tick_slow = (slow_cnt_q == SLOW_LAST);

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         req[i] = |pend_q[i];
      end
   end
   assign any_req = |req;

   audio_rr_arbiter #(.N(NCH), .PW(PW)) u_arb (
      .req_i (req),
      .ptr_i (rr_q),
      .gnt_o (gnt)
   );

   // Within the granted channel the highest pending stage goes first, so each stage
   // consumes its predecessor's value from before the current tick.
   always_comb begin
      gnt_ch    = '0;
      sel_stage = '0;
      sel_x     = '0;
      sel_s     = '0;
      for (int i = 0; i < NCH; i++) begin
         if (gnt[i]) begin
            gnt_ch = 2'(i);
            for (int k = 0; k < NSTAGE; k++) begin
               if (pend_q[i][k]) sel_stage = 2'(k);
            end
         end
      end
      for (int i = 0; i < NCH; i++) begin
         for (int k = 0; k < NSTAGE; k++) begin
            if (gnt[i] && sel_stage == 2'(k)) begin
               if (k == 0) sel_x = ch_in[i*W +: W];
               else        sel_x = ystore_q[i][(k == 0) ? 0 : k - 1];
               sel_s = sstore_q[i][k];
            end
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk_27m or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (any_req) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT:  if (eng.eng_done || timer_q == TMO_LAST) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs. eng_done outside WAIT (including a late done of an aborted job) is ignored.
   always_comb begin
      start_o  = (state_q == ST_ISSUE);
      grant_en = (state_q == ST_IDLE) && any_req;
      wb_en    = (state_q == ST_WAIT) && eng.eng_done;
      tmo_hit  = (state_q == ST_WAIT) && !eng.eng_done && (timer_q == TMO_LAST);
   end

   always_comb begin
      mid_cnt_d  = tick_mid  ? '0 : mid_cnt_q + MW'(1);
      slow_cnt_d = tick_slow ? '0 : slow_cnt_q + SW'(1);

      pend_d = pend_q;
      ovr_d  = ovr_clr ? '0 : ovr_q;
      rr_d   = rr_q;
      job_ch_d    = job_ch_q;
      job_stage_d = job_stage_q;
      job_x_d     = job_x_q;
      job_s_d     = job_s_q;

      if (grant_en) begin
         job_ch_d    = gnt_ch;
         job_stage_d = sel_stage;
         job_x_d     = sel_x;
         job_s_d     = sel_s;
         rr_d        = (gnt_ch == 2'(NCH - 1)) ? '0 : PW'(gnt_ch + 2'd1);
         for (int i = 0; i < NCH; i++) begin
            for (int k = 0; k < NSTAGE; k++) begin
               if (gnt[i] && sel_stage == 2'(k)) pend_d[i][k] = 1'b0;
            end
         end
      end

      // A tick on a bit that is still waiting (and not being issued right now) merges
      // into the existing job and flags overrun; setting beats a simultaneous clear.
      for (int i = 0; i < NCH; i++) begin
         for (int k = 0; k < NSTAGE; k++) begin
            if ((stage_rate(k) == RATE_MID && tick_mid) ||
                (stage_rate(k) == RATE_SLOW && tick_slow)) begin
               if (pend_d[i][k]) ovr_d[i] = 1'b1;
               pend_d[i][k] = 1'b1;
            end
         end
      end

      timer_d = timer_q;
      if (state_q == ST_ISSUE)     timer_d = '0;
      else if (state_q == ST_WAIT) timer_d = timer_q + TW'(1);

      ystore_d = ystore_q;
      sstore_d = sstore_q;
      oval_d   = '0;
      if (wb_en) begin
         for (int i = 0; i < NCH; i++) begin
            for (int k = 0; k < NSTAGE; k++) begin
               if (job_ch_q == 2'(i) && job_stage_q == 2'(k)) begin
                  ystore_d[i][k] = eng.eng_y;
                  sstore_d[i][k] = eng.eng_s_nxt;
                  if (k == NSTAGE - 1) oval_d[i] = 1'b1;
               end
            end
         end
      end

      tmo_d = tmo_q | tmo_hit;
   end

   always_ff @(posedge clk_27m or posedge reset) begin
      if (reset) begin
         mid_cnt_q   <= '0;
         slow_cnt_q  <= '0;
         pend_q      <= '0;
         ovr_q       <= '0;
         oval_q      <= '0;
         tmo_q       <= 1'b0;
         rr_q        <= '0;
         timer_q     <= '0;
         job_ch_q    <= '0;
         job_stage_q <= '0;
         job_x_q     <= '0;
         job_s_q     <= '0;
         ystore_q    <= '{default: '0};
         sstore_q    <= '{default: '0};
      end else begin
         mid_cnt_q   <= mid_cnt_d;
         slow_cnt_q  <= slow_cnt_d;
         pend_q      <= pend_d;
         ovr_q       <= ovr_d;
         oval_q      <= oval_d;
         tmo_q       <= tmo_d;
         rr_q        <= rr_d;
         timer_q     <= timer_d;
         job_ch_q    <= job_ch_d;
         job_stage_q <= job_stage_d;
         job_x_q     <= job_x_d;
         job_s_q     <= job_s_d;
         ystore_q    <= ystore_d;
         sstore_q    <= sstore_d;
      end
   end

   assign eng.eng_start = start_o;
   assign eng.eng_ch    = job_ch_q;
   assign eng.eng_stage = job_stage_q;
   assign eng.eng_x     = job_x_q;
   assign eng.eng_s     = job_s_q;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         ch_out[i*W +: W] = ystore_q[i][NSTAGE-1];
      end
   end
   assign out_valid = oval_q;
   assign overrun   = ovr_q;
   assign err_tmo   = tmo_q;

endmodule

// File: tb/tb_audio_filter_scheduler.sv
// tb/tb_audio_filter_scheduler.sv - directed self-checking bench for audio_filter_scheduler
module tb_audio_filter_scheduler;
   localparam int NCH = 3;
   localparam int W   = 12;

   logic             clk_27m = 1'b0;
   logic             reset   = 1'b1;
   logic [NCH*W-1:0] ch_in   = '0;
   logic [NCH*W-1:0] ch_out;
   logic [NCH-1:0]   out_valid;
   logic             ovr_clr = 1'b0;
   logic [NCH-1:0]   overrun;
   logic             err_tmo;

   audio_filter_scheduler_if #(.W(W)) eng_if ();

   logic         bfm_done  = 1'b0;
   logic         inj_done  = 1'b0;
   logic [W-1:0] bfm_y     = '0;
   logic [W-1:0] inj_y     = '0;
   int           bfm_delay = 1;
   bit           bfm_never = 1'b0;

   assign eng_if.eng_done  = bfm_done | inj_done;
   assign eng_if.eng_y     = bfm_done ? bfm_y : inj_y;
   assign eng_if.eng_s_nxt = bfm_done ? bfm_y : inj_y;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   always #5 clk_27m = ~clk_27m;

   audio_filter_scheduler #(
      .NCH(NCH), .W(W), .DIV_MID(27), .DIV_SLOW(270), .TIMEOUT(16)
   ) dut (
      .clk_27m   (clk_27m),
      .reset     (reset),
      .ch_in     (ch_in),
      .ch_out    (ch_out),
      .out_valid (out_valid),
      .eng       (eng_if),
      .ovr_clr   (ovr_clr),
      .overrun   (overrun),
      .err_tmo   (err_tmo)
   );

   // Engine model: y = s_nxt = x, done bfm_delay cycles after the start cycle.
   initial begin : bfm
      logic [W-1:0] x;
      forever begin
         @(negedge clk_27m);
         if (eng_if.eng_start === 1'b1 && !bfm_never) begin
            x = eng_if.eng_x;
            repeat (bfm_delay) @(posedge clk_27m);
            #1;
            bfm_y    = x;
            bfm_done = 1'b1;
            @(posedge clk_27m);
            #1;
            bfm_done = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk_27m);
      #1;
      cyc++;
   endtask

   task automatic step_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk_27m);
      @(posedge clk_27m);
      #1;
      reset = 1'b0;
      cyc = 0;
   endtask

   task automatic wait_start(input int limit);
      while (eng_if.eng_start !== 1'b1 && cyc < limit) step();
   endtask

   task automatic test_reset();
      ch_in     = {12'hABC, 12'h456, 12'h123};
      bfm_delay = 1;
      bfm_never = 1'b0;
      do_reset();
      vectors++; if (ch_out !== '0) begin miscompares++; $display("FAIL reset_ch_out: got %0h expected 0", ch_out); end
      vectors++; if (out_valid !== '0) begin miscompares++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
      vectors++; if (overrun !== '0) begin miscompares++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
      vectors++; if (err_tmo !== 1'b0) begin miscompares++; $display("FAIL reset_err_tmo: got %0b expected 0", err_tmo); end
      vectors++; if (eng_if.eng_start !== 1'b0) begin miscompares++; $display("FAIL reset_eng_start: got %0b expected 0", eng_if.eng_start); end
      wait_start(60);
      vectors++; if (cyc !== 28) begin miscompares++; $display("FAIL first_start_cycle: got %0d expected 28", cyc); end
   endtask

   // Continues from test_reset: the first tick_mid makes all six mid-rate jobs pending at once.
   task automatic test_grant_order();
      logic [1:0]   exp_ch [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
      logic [1:0]   exp_st [6] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
      logic [W-1:0] exp_x  [6] = '{12'h000, 12'h000, 12'h000, 12'h123, 12'h456, 12'hABC};
      for (int j = 0; j < 6; j++) begin
         if (j > 0) begin
            step();
            wait_start(cyc + 10);
         end
         vectors++; if (cyc !== 28 + 3*j) begin miscompares++; $display("FAIL grant%0d_cycle: got %0d expected %0d", j, cyc, 28 + 3*j); end
         vectors++; if (eng_if.eng_ch !== exp_ch[j]) begin miscompares++; $display("FAIL grant%0d_ch: got %0d expected %0d", j, eng_if.eng_ch, exp_ch[j]); end
         vectors++; if (eng_if.eng_stage !== exp_st[j]) begin miscompares++; $display("FAIL grant%0d_stage: got %0d expected %0d", j, eng_if.eng_stage, exp_st[j]); end
         vectors++; if (eng_if.eng_x !== exp_x[j]) begin miscompares++; $display("FAIL grant%0d_x: got %0h expected %0h", j, eng_if.eng_x, exp_x[j]); end
      end
   endtask

   task automatic test_stage_chain();
      int           pulses = 0;
      logic [W-1:0] seen [2] = '{12'hFFF, 12'hFFF};
      ch_in     = {12'h000, 12'h000, 12'h800};
      bfm_delay = 1;
      bfm_never = 1'b0;
      do_reset();
      while (cyc < 600) begin
         step();
         if (out_valid[0] === 1'b1) begin
            if (pulses < 2) seen[pulses] = ch_out[W-1:0];
            pulses++;
         end
      end
      vectors++; if (pulses !== 2) begin miscompares++; $display("FAIL chain_pulse_count: got %0d expected 2", pulses); end
      vectors++; if (seen[0] !== 12'h000) begin miscompares++; $display("FAIL chain_first_out: got %0h expected 0", seen[0]); end
      vectors++; if (seen[1] !== 12'h800) begin miscompares++; $display("FAIL chain_second_out: got %0h expected 800", seen[1]); end
      vectors++; if (ch_out[3*W-1:W] !== '0) begin miscompares++; $display("FAIL chain_other_ch: got %0h expected 0", ch_out[3*W-1:W]); end
   endtask

   task automatic test_timeout();
      ch_in     = {12'hABC, 12'h456, 12'h123};
      bfm_never = 1'b1;
      do_reset();
      wait_start(60);
      vectors++; if (cyc !== 28) begin miscompares++; $display("FAIL tmo_first_start: got %0d expected 28", cyc); end
      step_to(44);
      vectors++; if (err_tmo !== 1'b0) begin miscompares++; $display("FAIL tmo_before: got %0b expected 0", err_tmo); end
      step_to(45);
      vectors++; if (err_tmo !== 1'b1) begin miscompares++; $display("FAIL tmo_set: got %0b expected 1", err_tmo); end
      step_to(46);
      vectors++; if (eng_if.eng_start !== 1'b1 || eng_if.eng_ch !== 2'd1 || eng_if.eng_stage !== 2'd1) begin
         miscompares++; $display("FAIL tmo_next_job: got start=%0b ch=%0d stage=%0d expected 1/1/1", eng_if.eng_start, eng_if.eng_ch, eng_if.eng_stage);
      end
      step_to(63);
      inj_y    = 12'hFFF;
      inj_done = 1'b1;
      step();
      inj_done = 1'b0;
      vectors++; if (eng_if.eng_start !== 1'b1 || eng_if.eng_ch !== 2'd2 || eng_if.eng_stage !== 2'd1) begin
         miscompares++; $display("FAIL idle_done_ignored: got start=%0b ch=%0d stage=%0d expected 1/2/1", eng_if.eng_start, eng_if.eng_ch, eng_if.eng_stage);
      end
      vectors++; if (out_valid !== '0) begin miscompares++; $display("FAIL idle_done_out_valid: got %0b expected 0", out_valid); end
   endtask

   task automatic test_overrun();
      bfm_never = 1'b0;
      bfm_delay = 40;
      do_reset();
      step_to(53);
      vectors++; if (overrun !== 3'b000) begin miscompares++; $display("FAIL ovr_before: got %0b expected 000", overrun); end
      step_to(54);
      vectors++; if (overrun !== 3'b111) begin miscompares++; $display("FAIL ovr_set: got %0b expected 111", overrun); end
      step_to(60);
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      vectors++; if (overrun !== 3'b000) begin miscompares++; $display("FAIL ovr_clear: got %0b expected 000", overrun); end
      step_to(79);
      vectors++; if (overrun !== 3'b000) begin miscompares++; $display("FAIL ovr_stays_clear: got %0b expected 000", overrun); end
      step_to(80);
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      vectors++; if (overrun !== 3'b111) begin miscompares++; $display("FAIL ovr_set_beats_clear: got %0b expected 111", overrun); end
   endtask

   // Continues from test_overrun: FSM is in WAIT on job (0,1), engine done due 40 cycles after its start.
   task automatic test_reset_in_wait();
      step_to(82);
      vectors++; if (err_tmo !== 1'b1 || eng_if.eng_stage !== 2'd1) begin
         miscompares++; $display("FAIL pre_reset_state: got err_tmo=%0b stage=%0d expected 1/1", err_tmo, eng_if.eng_stage);
      end
      bfm_delay = 1;
      #2;
      reset = 1'b1;
      #1;
      vectors++; if (eng_if.eng_start !== 1'b0 || eng_if.eng_ch !== 2'd0 || eng_if.eng_stage !== 2'd0) begin
         miscompares++; $display("FAIL rst_eng_ctl: got start=%0b ch=%0d stage=%0d expected 0/0/0", eng_if.eng_start, eng_if.eng_ch, eng_if.eng_stage);
      end
      vectors++; if (eng_if.eng_x !== '0 || eng_if.eng_s !== '0) begin miscompares++; $display("FAIL rst_eng_data: got x=%0h s=%0h expected 0/0", eng_if.eng_x, eng_if.eng_s); end
      vectors++; if (overrun !== '0 || err_tmo !== 1'b0) begin miscompares++; $display("FAIL rst_flags: got ovr=%0b tmo=%0b expected 0/0", overrun, err_tmo); end
      vectors++; if (ch_out !== '0 || out_valid !== '0) begin miscompares++; $display("FAIL rst_outputs: got ch_out=%0h ov=%0b expected 0/0", ch_out, out_valid); end
      @(posedge clk_27m);
      @(posedge clk_27m);
      #1;
      reset = 1'b0;
      cyc = 0;
      step_to(27);
      vectors++; if (out_valid !== '0 || ch_out !== '0 || err_tmo !== 1'b0) begin
         miscompares++; $display("FAIL late_done_ignored: got ov=%0b ch_out=%0h tmo=%0b expected 0/0/0", out_valid, ch_out, err_tmo);
      end
      wait_start(60);
      vectors++; if (cyc !== 28 || eng_if.eng_ch !== 2'd0 || eng_if.eng_stage !== 2'd1) begin
         miscompares++; $display("FAIL resume_first: got cyc=%0d ch=%0d stage=%0d expected 28/0/1", cyc, eng_if.eng_ch, eng_if.eng_stage);
      end
      step();
      wait_start(60);
      vectors++; if (cyc !== 31 || eng_if.eng_ch !== 2'd1) begin
         miscompares++; $display("FAIL resume_second: got cyc=%0d ch=%0d expected 31/1", cyc, eng_if.eng_ch);
      end
      step_to(35);
      vectors++; if (err_tmo !== 1'b0) begin miscompares++; $display("FAIL resume_no_tmo: got %0b expected 0", err_tmo); end
   endtask

   initial begin
      test_reset();
      test_grant_order();
      test_stage_chain();
      test_timeout();
      test_overrun();
      test_reset_in_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
